// File: rtl/shannon_fano_codebook_ctrl.sv
// rtl/shannon_fano_codebook_ctrl.sv - Shannon-Fano codebook builder: load, bubble sort, stack-driven split, emit
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    probability load handshake; in_prob arrives in symbol order
//   out_valid/out_ready  codebook entry handshake; out_sym, out_code, out_len, out_last
//   busy                 high while sorting or splitting
module shannon_fano_codebook_ctrl #(
    parameter int NSYM   = 8,
    parameter int PW     = 8,
    parameter int CODE_W = NSYM - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PW-1:0]             in_prob,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NSYM)-1:0]   out_sym,
    output logic [CODE_W-1:0]         out_code,
    output logic [$clog2(NSYM):0]     out_len,
    output logic                      out_last,
    output logic                      busy
);
    localparam int IW = $clog2(NSYM);
    localparam int LW = IW + 1;
    localparam int SW = PW + IW;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSYM - 1);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_SORT,
        ST_POP,
        ST_SUM,
        ST_SCAN,
        ST_APPLY,
        ST_EMIT
    } state_t;

    state_t state, state_nx;

    // Sorted working list: probability and original symbol index per slot.
    logic [PW-1:0]     prob     [NSYM];
    logic [IW-1:0]     tag      [NSYM];
    // Code tables indexed by original symbol.
    logic [CODE_W-1:0] code_tab [NSYM];
    logic [LW-1:0]     len_tab  [NSYM];
    // Range stack. Stacked ranges are disjoint and non-empty, so NSYM entries suffice.
    logic [IW-1:0]     stk_lo   [NSYM];
    logic [IW-1:0]     stk_hi   [NSYM];
    logic [LW-1:0]     sp;

    logic [IW-1:0] ld_cnt, em_cnt, sort_p, sort_j;
    logic [IW-1:0] lo, hi, idx, best_k;
    logic [SW-1:0] sum, prefix;
    logic [SW:0]   best_diff;

    logic          load_fire, out_fire, sort_row_end, sort_done, do_swap;
    logic [IW-1:0] sort_j1, sp_ix, sp_ix1, top_ix;
    logic [SW-1:0] prefix_nx;
    logic [SW:0]   two_p, sum_x, diff;

    always_comb begin
        load_fire    = (state == ST_LOAD) && in_valid;
        out_fire     = (state == ST_EMIT) && out_ready;
        sort_j1      = sort_j + IW'(1);
        sort_row_end = (sort_j == LAST_IDX - IW'(1) - sort_p);
        sort_done    = sort_row_end && (sort_p == LAST_IDX - IW'(1));
        do_swap      = prob[sort_j] < prob[sort_j1];
        sp_ix        = sp[IW-1:0];
        sp_ix1       = sp_ix + IW'(1);
        // sp == NSYM truncates to 0 here; minus one still lands on the top entry.
        top_ix       = sp_ix - IW'(1);
        prefix_nx    = prefix + SW'(prob[idx]);
        two_p        = {prefix_nx, 1'b0};
        sum_x        = {1'b0, sum};
        diff         = (two_p >= sum_x) ? (two_p - sum_x) : (sum_x - two_p);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_sym   = '0;
        out_code  = '0;
        out_len   = '0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (load_fire && (ld_cnt == LAST_IDX)) state_nx = ST_SORT;
            end
            ST_SORT: begin
                busy = 1'b1;
                if (sort_done) state_nx = ST_POP;
            end
            ST_POP: begin
                busy = 1'b1;
                if (sp == '0) begin
                    state_nx = ST_EMIT;
                end else if (stk_lo[top_ix] != stk_hi[top_ix]) begin
                    state_nx = ST_SUM;
                end
            end
            ST_SUM: begin
                busy = 1'b1;
                if (idx == hi) state_nx = ST_SCAN;
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (idx == hi - IW'(1)) state_nx = ST_APPLY;
            end
            ST_APPLY: begin
                busy     = 1'b1;
                state_nx = ST_POP;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                out_sym   = em_cnt;
                out_code  = code_tab[em_cnt];
                out_len   = len_tab[em_cnt];
                out_last  = (em_cnt == LAST_IDX);
                if (out_fire && (em_cnt == LAST_IDX)) state_nx = ST_LOAD;
            end
            default: state_nx = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSYM; s++) begin
                prob[s]     <= '0;
                tag[s]      <= '0;
                code_tab[s] <= '0;
                len_tab[s]  <= '0;
                stk_lo[s]   <= '0;
                stk_hi[s]   <= '0;
            end
            sp        <= '0;
            ld_cnt    <= '0;
            em_cnt    <= '0;
            sort_p    <= '0;
            sort_j    <= '0;
            lo        <= '0;
            hi        <= '0;
            idx       <= '0;
            best_k    <= '0;
            sum       <= '0;
            prefix    <= '0;
            best_diff <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_fire) begin
                        prob[ld_cnt] <= in_prob;
                        tag[ld_cnt]  <= ld_cnt;
                        ld_cnt       <= ld_cnt + IW'(1);  // wraps to 0 after the last symbol
                        sort_p       <= '0;
                        sort_j       <= '0;
                    end
                end
                ST_SORT: begin
                    // Strict compare keeps equal probabilities in arrival order.
                    if (do_swap) begin
                        prob[sort_j]  <= prob[sort_j1];
                        prob[sort_j1] <= prob[sort_j];
                        tag[sort_j]   <= tag[sort_j1];
                        tag[sort_j1]  <= tag[sort_j];
                    end
                    if (sort_done) begin
                        sort_p    <= '0;
                        sort_j    <= '0;
                        stk_lo[0] <= '0;
                        stk_hi[0] <= LAST_IDX;
                        sp        <= LW'(1);
                    end else if (sort_row_end) begin
                        sort_p <= sort_p + IW'(1);
                        sort_j <= '0;
                    end else begin
                        sort_j <= sort_j1;
                    end
                end
                ST_POP: begin
                    if (sp != '0) begin
                        lo  <= stk_lo[top_ix];
                        hi  <= stk_hi[top_ix];
                        idx <= stk_lo[top_ix];
                        sp  <= sp - LW'(1);
                        sum <= '0;
                    end
                end
                ST_SUM: begin
                    sum <= sum + SW'(prob[idx]);
                    if (idx == hi) begin
                        idx       <= lo;
                        prefix    <= '0;
                        best_k    <= lo;
                        best_diff <= '1;  // above any reachable |2*prefix - S|
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ST_SCAN: begin
                    prefix <= prefix_nx;
                    // Strict less-than keeps the smallest k on a tie.
                    if (diff < best_diff) begin
                        best_diff <= diff;
                        best_k    <= idx;
                    end
                    idx <= idx + IW'(1);
                end
                ST_APPLY: begin
                    for (int s = 0; s < NSYM; s++) begin
                        if ((IW'(s) >= lo) && (IW'(s) <= hi)) begin
                            code_tab[tag[s]] <= (code_tab[tag[s]] << 1) | CODE_W'(IW'(s) > best_k);
                            len_tab[tag[s]]  <= len_tab[tag[s]] + LW'(1);
                        end
                    end
                    // Upper half goes in first so the lower half is popped next.
                    stk_lo[sp_ix]  <= best_k + IW'(1);
                    stk_hi[sp_ix]  <= hi;
                    stk_lo[sp_ix1] <= lo;
                    stk_hi[sp_ix1] <= best_k;
                    sp             <= sp + LW'(2);
                end
                ST_EMIT: begin
                    if (out_fire) begin
                        em_cnt <= em_cnt + IW'(1);
                        if (em_cnt == LAST_IDX) begin
                            for (int s = 0; s < NSYM; s++) begin
                                code_tab[s] <= '0;
                                len_tab[s]  <= '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shannon_fano_codebook_ctrl.sv
// tb/tb_shannon_fano_codebook_ctrl.sv - self-checking bench for shannon_fano_codebook_ctrl
module tb_shannon_fano_codebook_ctrl;
    localparam int NSYM   = 8;
    localparam int PW     = 8;
    localparam int CODE_W = NSYM - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [PW-1:0]       in_prob;
    logic                out_valid;
    logic                out_ready;
    logic [2:0]          out_sym;
    logic [CODE_W-1:0]   out_code;
    logic [3:0]          out_len;
    logic                out_last;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;
    int probs    [NSYM];
    int exp_code [NSYM];
    int exp_len  [NSYM];

    always #5 clk = ~clk;

    shannon_fano_codebook_ctrl #(.NSYM(NSYM), .PW(PW), .CODE_W(CODE_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_prob  (in_prob),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sym  (out_sym),
        .out_code (out_code),
        .out_len  (out_len),
        .out_last (out_last),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_out_last"}, 32'(out_last), 0);
        check({tag, "_out_fields"}, {17'd0, out_sym, out_len, 1'b0, out_code}, 0);
    endtask

    // Reference: stable descending order, then Shannon-Fano splits over a work list.
    task automatic model();
        int ord [NSYM];
        int qlo [$];
        int qhi [$];
        int lo, hi, s, pre, best, bd, d, key, j;
        for (int i = 0; i < NSYM; i++) begin
            ord[i] = i;
            exp_code[i] = 0;
            exp_len[i] = 0;
        end
        for (int i = 1; i < NSYM; i++) begin
            key = ord[i];
            j = i - 1;
            while (j >= 0 && probs[ord[j]] < probs[key]) begin
                ord[j+1] = ord[j];
                j--;
            end
            ord[j+1] = key;
        end
        qlo.push_back(0);
        qhi.push_back(NSYM - 1);
        while (qlo.size() > 0) begin
            lo = qlo.pop_back();
            hi = qhi.pop_back();
            if (lo == hi) continue;
            s = 0;
            for (int t = lo; t <= hi; t++) s += probs[ord[t]];
            pre = 0;
            best = lo;
            bd = -1;
            for (int t = lo; t < hi; t++) begin
                pre += probs[ord[t]];
                d = 2 * pre - s;
                if (d < 0) d = -d;
                if (bd < 0 || d < bd) begin
                    bd = d;
                    best = t;
                end
            end
            for (int t = lo; t <= hi; t++) begin
                exp_code[ord[t]] = exp_code[ord[t]] * 2 + ((t > best) ? 1 : 0);
                exp_len[ord[t]]++;
            end
            qlo.push_back(best + 1); qhi.push_back(hi);
            qlo.push_back(lo);       qhi.push_back(best);
        end
    endtask

    task automatic set_uniform(input int p);
        for (int i = 0; i < NSYM; i++) begin
            probs[i] = p;
            exp_code[i] = i;
            exp_len[i] = 3;
        end
    endtask

    // gap_mode: 0 none, 1 alternate cycles, 2 random
    task automatic load_probs(input int gap_mode);
        int  idx = 0;
        int  cyc = 0;
        bit  alt = 1'b1;
        logic fire;
        while (idx < NSYM && cyc < 500) begin
            case (gap_mode)
                0:       in_valid = 1'b1;
                1:       begin in_valid = alt; alt = !alt; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_prob = PW'(probs[idx]);
            check("in_ready_load", 32'(in_ready), 1);
            fire = in_valid && in_ready;
            tick();
            cyc++;
            if (fire) idx++;
        end
        in_valid = 1'b0;
        check("load_count", idx, NSYM);
        check("in_ready_sort", 32'(in_ready), 0);
        check("busy_sort", 32'(busy), 1);
    endtask

    task automatic finish_build(input bit pulse, input int stall_sym, input bit rand_ready);
        int   busy_cyc = 0;
        int   cyc = 0;
        int   n = 0;
        bit   stalled = 1'b0;
        logic fire;
        while (!out_valid && cyc < 2000) begin
            if (busy) busy_cyc++;
            check("in_ready_busy", 32'(in_ready), 0);
            if (pulse) begin
                in_valid = 1'($urandom_range(0, 1));
                in_prob  = PW'($urandom);
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("emit_reached", 32'(out_valid), 1);
        check("busy_cycles_ok", 32'(busy_cyc >= 28 && busy_cyc <= 28 + 4 * NSYM * NSYM), 1);
        check("busy_emit", 32'(busy), 0);
        cyc = 0;
        while (n < NSYM && cyc < 2000) begin
            check("out_valid", 32'(out_valid), 1);
            check("out_sym", 32'(out_sym), n);
            check("out_code", 32'(out_code), exp_code[n]);
            check("out_len", 32'(out_len), exp_len[n]);
            check("out_last", 32'(out_last), (n == NSYM - 1) ? 1 : 0);
            if (n == stall_sym && !stalled) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    cyc++;
                    check("stall_valid", 32'(out_valid), 1);
                    check("stall_sym", 32'(out_sym), n);
                    check("stall_code", 32'(out_code), exp_code[n]);
                    check("stall_len", 32'(out_len), exp_len[n]);
                end
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            fire = out_valid && out_ready;
            tick();
            cyc++;
            if (fire) n++;
        end
        out_ready = 1'b1;
        check("emit_count", n, NSYM);
        check_idle("post_emit");
    endtask

    initial begin
        int geo_code [NSYM] = '{'h7F, 'h7E, 'h3E, 'h1E, 'h0E, 'h06, 'h02, 'h00};
        int geo_len  [NSYM] = '{7, 7, 6, 5, 4, 3, 2, 1};
        int zero_code[NSYM] = '{'h00, 'h02, 'h06, 'h0E, 'h1E, 'h3E, 'h7E, 'h7F};
        int zero_len [NSYM] = '{1, 2, 3, 4, 5, 6, 7, 7};
        int narrow;

        rst = 1'b1;
        in_valid = 1'b0;
        in_prob = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("after_reset");

        // Uniform
        set_uniform(32);
        load_probs(0);
        finish_build(1'b0, -1, 1'b0);

        // Geometric
        for (int i = 0; i < NSYM; i++) begin
            probs[i] = 1 << i;
            exp_code[i] = geo_code[i];
            exp_len[i] = geo_len[i];
        end
        load_probs(0);
        finish_build(1'b0, -1, 1'b0);

        // All zero
        for (int i = 0; i < NSYM; i++) begin
            probs[i] = 0;
            exp_code[i] = zero_code[i];
            exp_len[i] = zero_len[i];
        end
        load_probs(0);
        finish_build(1'b0, -1, 1'b0);

        // Backpressure on symbol 3
        set_uniform(32);
        load_probs(0);
        finish_build(1'b0, 3, 1'b0);

        // Reset ten cycles into SORT
        set_uniform(77);
        load_probs(0);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("midsort_in_ready", 32'(in_ready), 1);
        check("midsort_busy", 32'(busy), 0);
        check("midsort_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        set_uniform(32);
        load_probs(0);
        finish_build(1'b0, -1, 1'b0);

        // Max values, alternate-cycle gaps, in_valid pulses during SORT/SPLIT
        set_uniform(255);
        load_probs(1);
        finish_build(1'b1, -1, 1'b0);

        // Randomised runs against the reference model
        for (int r = 0; r < 8; r++) begin
            narrow = $urandom_range(0, 1);
            for (int i = 0; i < NSYM; i++)
                probs[i] = narrow ? $urandom_range(0, 3) : $urandom_range(0, 255);
            model();
            load_probs(2);
            finish_build(1'b1, $urandom_range(0, NSYM - 1), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shannon_fano_codebook_ctrl.md
Name: shannon_fano_codebook_ctrl

Overview:
- Sequential controller that builds a Shannon-Fano codebook for NSYM symbols.
- Loads probabilities serially, sorts them descending with one compare-swap per cycle, then recursively partitions the sorted list using an explicit range stack.
- Streams (symbol, code, length) entries in original symbol order over valid/ready.
- Sits between the probability-estimation front end and the bit-packing encoder.

Parameters:
- NSYM, 8, number of symbols (power of two, 2..16).
- PW, 8, probability word width.
- CODE_W, NSYM-1, maximum code length and width of the code register.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_prob valid.
- in_ready  out  1  block accepts in_prob.
- in_prob  in  PW  probability of the next symbol; arrival order defines the symbol index.
- out_valid  out  1  codebook entry valid.
- out_ready  in  1  consumer accepts the entry.
- out_sym  out  $clog2(NSYM)  symbol index.
- out_code  out  CODE_W  codeword, right-aligned, first bit at position len-1, unused upper bits 0.
- out_len  out  $clog2(NSYM)+1  code length in bits (1..CODE_W).
- out_last  out  1  asserted with the entry for symbol NSYM-1.
- busy  out  1  high in SORT and SPLIT.

Behaviour:
- Reset, asynchronous, any state: state=LOAD, load counter=0, stack empty, all code/len registers 0, in_ready=1, out_valid=0, out_last=0, busy=0, out_sym/out_code/out_len=0. An in-flight build is discarded.
- Clocking: one clock domain, rising edge only.
- States: LOAD -> SORT -> SPLIT -> EMIT -> LOAD.
- LOAD:
  - in_ready=1. Each in_valid&&in_ready cycle stores in_prob at slot = counter, with tag = counter.
  - Gaps in in_valid are allowed.
  - After the NSYM-th handshake, go to SORT on the next cycle; in_ready=0 in that cycle.
- SORT:
  - Bubble sort over (prob, tag) pairs, descending.
  - Exactly one adjacent compare-swap per cycle. The compare sequence is pass p=0..NSYM-2 and j=0..NSYM-2-p, giving exactly NSYM*(NSYM-1)/2 cycles (28 at default).
  - Swap only if prob[j] < prob[j+1], strictly. Equal probabilities therefore keep the lower tag first (stable).
- SPLIT:
  - Push range [0,NSYM-1], then loop until the stack is empty.
  - Pop [lo,hi]. If lo==hi, the range is a leaf and is discarded.
  - Otherwise:
    - Accumulate S = sum of prob[lo..hi], one element per cycle.
    - Scan k=lo..hi-1, one per cycle, minimising |2*prefix(lo..k) - S|. On a tie, keep the smaller k.
    - In one apply cycle: for every slot in lo..k, code = (code<<1)|0 and len += 1; for every slot in k+1..hi, code = (code<<1)|1 and len += 1. Code and len are stored in the table indexed by the slot's tag.
    - Push [k+1,hi], then [lo,k] (so [lo,k] is processed first).
- Arithmetic: sums use PW+$clog2(NSYM) bits and the 2*prefix compare uses one extra bit, so there is no overflow at all-max inputs.
- Stack depth: NSYM entries.
- SPLIT duration is data-dependent but bounded at 4*NSYM*NSYM cycles. The bench must not rely on exact SPLIT timing.
- All-zero or tied probabilities are legal. Ties always resolve to the smallest k, so results are deterministic.
- EMIT:
  - Entries are output for symbol 0..NSYM-1.
  - out_valid=1. Entry fields are held stable while out_valid&&!out_ready.
  - The entry advances on a handshake. out_last=1 only for symbol NSYM-1.
  - After the last handshake: out_valid=0 and in_ready=1 in the next cycle (state LOAD), and the code/len tables are cleared.
- in_valid outside LOAD is ignored, since in_ready=0.
- busy=0 in LOAD and EMIT.

Test Plan:
- Uniform input: all 8 probs = 32, out_ready=1 -> 28 SORT cycles with busy=1; symbol i gets out_code=i, out_len=3 for i=0..7; out_last only on sym 7.
- Geometric input: probs 1,2,4,8,16,32,64,128 for sym0..7 -> sym7 code 0x00 len1; sym6 0x02 len2; sym5 0x06 len3; sym4 0x0E len4; sym3 0x1E len5; sym2 0x3E len6; sym1 0x7E len7; sym0 0x7F len7.
- All-zero input -> stable order with k=lo at every split; sym0 0x00 len1, sym1 0x02 len2, ..., sym6 0x7E len7, sym7 0x7F len7.
- Backpressure: uniform run with out_ready=0 for 5 cycles while sym 3 is presented -> sym 3 entry (0x3, len 3) stable all 5 cycles; no entry skipped or duplicated; 8 handshakes total.
- Reset mid-SORT: assert rst 10 cycles into SORT -> same cycle in_ready=1, busy=0, out_valid=0. A following uniform run matches scenario 1.
- Input gaps and max values: 8 probs of 255 with in_valid low on alternate cycles, plus in_valid pulses during SORT -> only the 8 LOAD handshakes are accepted; codes equal uniform-case codes (no sum overflow).
